// File: rtl/idu1_sb.sv
// rtl/idu1_sb.sv - decode-to-issue stage: register file, scoreboard, operand capture, output register
// Optional macro IDU1_SB_FWD_EN: same-cycle writeback bypass into operand capture and scoreboard clear.
module idu1_sb #(
  parameter int              XLEN                     = 32,
  parameter int              NUM_WB                   = 2,
  parameter int              CTRL_W                   = 64,
  parameter logic [XLEN-1:0] STACK_POINTER_INIT_VALUE = 32'h80000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_rs1_en,
  input  logic [4:0]             in_rs1_addr,
  input  logic                   in_rs2_en,
  input  logic [4:0]             in_rs2_addr,
  input  logic                   in_rd_en,
  input  logic [4:0]             in_rd_addr,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_rs1_data,
  output logic [XLEN-1:0]        out_rs2_data,
  output logic                   out_rd_en,
  output logic [4:0]             out_rd_addr,
  output logic [CTRL_W-1:0]      out_ctrl,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*5-1:0]    wb_addr,
  input  logic [NUM_WB*XLEN-1:0] wb_data,
  input  logic                   flush,
  output logic [31:0]            sb_pending
);

  logic [XLEN-1:0] rf [1:31];
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic [31:0]     wb_hit;
  logic [31:0]     clr;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) wb_hit[wb_addr[i*5 +: 5]] = 1'b1;
    end
    wb_hit[0] = 1'b0;
  end

`ifdef IDU1_SB_FWD_EN
  assign clr = wb_hit;
`else
  assign clr = '0;
`endif

  assign hazard = in_valid &
                  ((in_rs1_en & pending[in_rs1_addr] & ~clr[in_rs1_addr]) |
                   (in_rs2_en & pending[in_rs2_addr] & ~clr[in_rs2_addr]) |
                   (in_rd_en  & pending[in_rd_addr]  & ~clr[in_rd_addr]));
  assign in_ready   = (~out_valid | out_ready) & ~hazard & ~flush;
  assign accept     = in_valid & in_ready;
  assign sb_pending = pending;

  // Later ports overwrite earlier ones, so the highest-index match supplies the bypass value.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (in_rs1_en && in_rs1_addr != 5'd0) rs1_val = rf[in_rs1_addr];
    if (in_rs2_en && in_rs2_addr != 5'd0) rs2_val = rf[in_rs2_addr];
`ifdef IDU1_SB_FWD_EN
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && in_rs1_en && in_rs1_addr != 5'd0 && wb_addr[i*5 +: 5] == in_rs1_addr)
        rs1_val = wb_data[i*XLEN +: XLEN];
      if (wb_valid[i] && in_rs2_en && in_rs2_addr != 5'd0 && wb_addr[i*5 +: 5] == in_rs2_addr)
        rs2_val = wb_data[i*XLEN +: XLEN];
    end
`endif
  end

  // Set after clear so a same-cycle accept keeps the register pending.
  always_comb begin
    pending_nxt = pending & ~wb_hit;
    if (flush && out_valid && out_rd_en) pending_nxt[out_rd_addr] = 1'b0;
    if (accept && in_rd_en) pending_nxt[in_rd_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) rf[r] <= (r == 2) ? STACK_POINTER_INIT_VALUE : '0;
    end else begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i] && wb_addr[i*5 +: 5] != 5'd0)
          rf[wb_addr[i*5 +: 5]] <= wb_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      out_valid    <= 1'b0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_rd_en    <= 1'b0;
      out_rd_addr  <= '0;
      out_ctrl     <= '0;
    end else begin
      pending <= pending_nxt;
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_rs1_data <= rs1_val;
        out_rs2_data <= rs2_val;
        out_rd_en    <= in_rd_en;
        out_rd_addr  <= in_rd_addr;
        out_ctrl     <= in_ctrl;
      end
    end
  end

  // A writeback must always retire a register the scoreboard is tracking.
  for (genvar g = 0; g < NUM_WB; g++) begin : g_wb_chk
    wb_to_pending_a: assert property (@(posedge clk) disable iff (!rst_n)
      (wb_valid[g] && wb_addr[g*5 +: 5] != 5'd0) |-> pending[wb_addr[g*5 +: 5]]);
  end

endmodule

// File: tb/tb_idu1_sb.sv
// tb/tb_idu1_sb.sv - self-checking bench for idu1_sb: vector table, directed corner sequences, random vs model
module tb_idu1_sb;

`ifdef IDU1_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        in_rs1_en, in_rs2_en, in_rd_en;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [63:0] in_ctrl;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic        out_rd_en;
  logic [4:0]  out_rd_addr;
  logic [63:0] out_ctrl;
  logic [1:0]  wbv;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic        flush;
  logic [31:0] sb_pending;

  assign wb_addr = {wa[1], wa[0]};
  assign wb_data = {wd[1], wd[0]};

  always #5 clk = ~clk;

  idu1_sb dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_en(in_rs1_en), .in_rs1_addr(in_rs1_addr),
    .in_rs2_en(in_rs2_en), .in_rs2_addr(in_rs2_addr),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_ctrl(out_ctrl),
    .wb_valid(wbv), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .sb_pending(sb_pending)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_rs1_en = 0; in_rs1_addr = 0; in_rs2_en = 0; in_rs2_addr = 0;
    in_rd_en = 0; in_rd_addr = 0; in_ctrl = '0;
    out_ready = 1; flush = 0; wbv = 0;
    wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic instr(input logic r1e, input logic [4:0] r1, input logic rde, input logic [4:0] rd,
                       input logic [63:0] c);
    in_valid = 1; in_rs1_en = r1e; in_rs1_addr = r1; in_rd_en = rde; in_rd_addr = rd; in_ctrl = c;
  endtask

  task automatic wb(input int p, input logic [4:0] a, input logic [31:0] d);
    wbv[p] = 1'b1; wa[p] = a; wd[p] = d;
  endtask

  typedef struct {
    logic        iv;
    logic        r1e;
    logic [4:0]  r1;
    logic        rde;
    logic [4:0]  rd;
    logic        ordy;
    logic        fl;
    logic [1:0]  wbv;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        e_ready;
    logic        e_ov;
    logic [31:0] e_rs1;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic r1e, logic [4:0] r1, logic rde, logic [4:0] rd,
                              logic ordy, logic fl, logic [1:0] wv, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1,
                              logic er, logic eov, logic [31:0] ers1, logic [31:0] epend);
    vec_t v;
    v.iv = iv; v.r1e = r1e; v.r1 = r1; v.rde = rde; v.rd = rd; v.ordy = ordy; v.fl = fl;
    v.wbv = wv; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.e_ready = er; v.e_ov = eov; v.e_rs1 = ers1; v.e_pend = epend;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pend;
  logic        m_ov;
  logic [31:0] m_rs1, m_rs2;
  logic        m_rde;
  logic [4:0]  m_rd;
  logic [63:0] m_ctrl;

  function automatic logic [31:0] opnd(logic en, logic [4:0] a);
    logic [31:0] v;
    if (!en || a == 5'd0) return 32'd0;
    v = m_rf[a];
    if (FWD) begin
      for (int p = 0; p < 2; p++)
        if (wbv[p] && wa[p] == a) v = wd[p];
    end
    return v;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e_ready, haz, acc;
    logic [31:0] clr, n_rs1, n_rs2;
    int          plist[$];

    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Vector table: one row per cycle; expectations reflect state after previous rows.
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b00,0,0,0,0,           1,0,32'h0,32'h0));
    tbl.push_back(mk(1,1,2,1,5, 1,0, 2'b00,0,0,0,0,           1,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b00,0,0,0,0,           1,1,32'h80000000,32'h20));
    tbl.push_back(mk(1,1,5,0,0, 1,0, 2'b00,0,0,0,0,           0,0,32'h80000000,32'h20));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b01,5,32'hDEADBEEF,0,0,1,0,32'h80000000,32'h20));
    tbl.push_back(mk(1,1,5,0,0, 1,0, 2'b00,0,0,0,0,           1,0,32'h80000000,32'h0));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b00,0,0,0,0,           1,1,32'hDEADBEEF,32'h0));
    tbl.push_back(mk(1,0,0,1,3, 1,0, 2'b00,0,0,0,0,           1,0,32'hDEADBEEF,32'h0));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b11,3,32'd1,3,32'd2,   1,1,32'h0,32'h8));
    tbl.push_back(mk(1,1,3,0,0, 1,0, 2'b00,0,0,0,0,           1,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b00,0,0,0,0,           1,1,32'd2,32'h0));
    tbl.push_back(mk(1,0,0,1,7, 0,0, 2'b00,0,0,0,0,           1,0,32'd2,32'h0));
    tbl.push_back(mk(0,0,0,0,0, 0,1, 2'b00,0,0,0,0,           0,1,32'h0,32'h80));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b00,0,0,0,0,           1,0,32'h0,32'h0));
    tbl.push_back(mk(1,1,0,1,0, 1,0, 2'b00,0,0,0,0,           1,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,0, 1,0, 2'b00,0,0,0,0,           1,1,32'h0,32'h0));

    foreach (tbl[k]) begin
      tick();
      if (tbl[k].iv) instr(tbl[k].r1e, tbl[k].r1, tbl[k].rde, tbl[k].rd, 64'(k));
      out_ready = tbl[k].ordy;
      flush     = tbl[k].fl;
      if (tbl[k].wbv[0]) wb(0, tbl[k].wa0, tbl[k].wd0);
      if (tbl[k].wbv[1]) wb(1, tbl[k].wa1, tbl[k].wd1);
      #1;
      chk($sformatf("vec%0d in_ready", k),   64'(in_ready),     64'(tbl[k].e_ready));
      chk($sformatf("vec%0d out_valid", k),  64'(out_valid),    64'(tbl[k].e_ov));
      chk($sformatf("vec%0d out_rs1", k),    64'(out_rs1_data), 64'(tbl[k].e_rs1));
      chk($sformatf("vec%0d sb_pending", k), 64'(sb_pending),   64'(tbl[k].e_pend));
    end

    // Backpressure: outputs frozen while out_ready is low, then back-to-back drain.
    tick(); instr(1, 3, 0, 0, 64'hAAAA); #1;
    chk("bp accept", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick(); instr(1, 5, 0, 0, 64'hBBBB); out_ready = 0; #1;
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp out_rs1", 64'(out_rs1_data), 64'd2);
      chk("bp out_ctrl", out_ctrl, 64'hAAAA);
    end
    tick(); instr(1, 5, 0, 0, 64'hBBBB); #1;
    chk("bp release ready", 64'(in_ready), 64'd1);
    chk("bp release rs1", 64'(out_rs1_data), 64'd2);
    tick(); #1;
    chk("bp b2b valid", 64'(out_valid), 64'd1);
    chk("bp b2b rs1", 64'(out_rs1_data), 64'hDEADBEEF);
    chk("bp b2b ctrl", out_ctrl, 64'hBBBB);
    tick(); #1;
    chk("bp drained", 64'(out_valid), 64'd0);

    // RAW dependency resolved by a writeback.
    tick(); instr(0, 0, 1, 5, 64'h34); #1;
    chk("raw producer ready", 64'(in_ready), 64'd1);
    tick(); #1;
    chk("raw pending x5", 64'(sb_pending), 64'h20);
    tick(); instr(1, 5, 0, 0, 64'h35); wb(0, 5, 32'h0BADF00D); #1;
    chk("raw wb-cycle ready", 64'(in_ready), 64'(FWD));
`ifdef IDU1_SB_FWD_EN
    tick(); #1;
    chk("raw fwd valid", 64'(out_valid), 64'd1);
    chk("raw fwd rs1", 64'(out_rs1_data), 64'h0BADF00D);
    chk("raw fwd pending", 64'(sb_pending), 64'h0);
`else
    tick(); instr(1, 5, 0, 0, 64'h35); #1;
    chk("raw late ready", 64'(in_ready), 64'd1);
    chk("raw late pending", 64'(sb_pending), 64'h0);
    tick(); #1;
    chk("raw late valid", 64'(out_valid), 64'd1);
    chk("raw late rs1", 64'(out_rs1_data), 64'h0BADF00D);
`endif
    tick();

    // WAW on x9 with a same-cycle writeback: set wins over clear.
    tick(); instr(0, 0, 1, 9, 64'h38); #1;
    chk("waw first ready", 64'(in_ready), 64'd1);
    tick(); #1;
    chk("waw pending x9", 64'(sb_pending), 64'h200);
    tick(); instr(0, 0, 1, 9, 64'h39); wb(0, 9, 32'h99); #1;
    chk("waw wb-cycle ready", 64'(in_ready), 64'(FWD));
`ifdef IDU1_SB_FWD_EN
    tick(); wb(0, 9, 32'h9A); #1;
    chk("waw set wins", 64'(sb_pending), 64'h200);
    tick(); #1;
    chk("waw final clear", 64'(sb_pending), 64'h0);
`else
    tick(); instr(0, 0, 1, 9, 64'h39); #1;
    chk("waw late ready", 64'(in_ready), 64'd1);
    chk("waw late cleared", 64'(sb_pending), 64'h0);
    tick(); wb(0, 9, 32'h9A); #1;
    chk("waw re-pending", 64'(sb_pending), 64'h200);
    tick(); #1;
    chk("waw final clear", 64'(sb_pending), 64'h0);
`endif
    tick(); tick();

    // Asynchronous reset in mid-operation.
    tick(); instr(0, 0, 1, 4, 64'h44); #1;
    chk("rst pre accept", 64'(in_ready), 64'd1);
    tick(); out_ready = 0; #1;
    chk("rst pre valid", 64'(out_valid), 64'd1);
    chk("rst pre pending", 64'(sb_pending), 64'h10);
    rst_n = 0; #1;
    chk("rst async valid", 64'(out_valid), 64'd0);
    chk("rst async pending", 64'(sb_pending), 64'h0);
    chk("rst async ctrl", out_ctrl, 64'h0);
    tick();
    tick(); rst_n = 1; instr(1, 2, 1, 4, 64'h45); #1;
    chk("rst release ready", 64'(in_ready), 64'd1);
    tick(); #1;
    chk("rst x2 valid", 64'(out_valid), 64'd1);
    chk("rst x2 value", 64'(out_rs1_data), 64'h80000000);

    // Random phase against the reference model, from a clean reset.
    tick(); rst_n = 0;
    tick(); tick(); rst_n = 1;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
    m_rf[2] = 32'h80000000;
    m_pend = '0; m_ov = 0; m_rs1 = 0; m_rs2 = 0; m_rde = 0; m_rd = 0; m_ctrl = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      in_valid    = 1'($urandom_range(0, 1));
      in_rs1_en   = 1'($urandom_range(0, 1));
      in_rs1_addr = 5'($urandom_range(0, 7));
      in_rs2_en   = 1'($urandom_range(0, 1));
      in_rs2_addr = 5'($urandom_range(0, 7));
      in_rd_en    = 1'($urandom_range(0, 1));
      in_rd_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      in_ctrl     = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      plist.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) plist.push_back(r);
      for (int p = 0; p < 2; p++) begin
        if (plist.size() > 0 && $urandom_range(0, 2) == 0)
          wb(p, 5'(plist[$urandom_range(0, plist.size() - 1)]), $urandom);
      end
      #1;
      clr = '0;
      if (FWD) for (int p = 0; p < 2; p++) if (wbv[p]) clr[wa[p]] = 1'b1;
      haz = in_valid && ((in_rs1_en && m_pend[in_rs1_addr] && !clr[in_rs1_addr]) ||
                         (in_rs2_en && m_pend[in_rs2_addr] && !clr[in_rs2_addr]) ||
                         (in_rd_en  && m_pend[in_rd_addr]  && !clr[in_rd_addr]));
      e_ready = (!m_ov || out_ready) && !haz && !flush;
      chk("rnd in_ready",   64'(in_ready),     64'(e_ready));
      chk("rnd out_valid",  64'(out_valid),    64'(m_ov));
      chk("rnd sb_pending", 64'(sb_pending),   64'(m_pend));
      chk("rnd out_rs1",    64'(out_rs1_data), 64'(m_rs1));
      chk("rnd out_rs2",    64'(out_rs2_data), 64'(m_rs2));
      chk("rnd out_rd",     64'({out_rd_en, out_rd_addr}), 64'({m_rde, m_rd}));
      chk("rnd out_ctrl",   out_ctrl,          m_ctrl);

      acc   = in_valid && e_ready;
      n_rs1 = opnd(in_rs1_en, in_rs1_addr);
      n_rs2 = opnd(in_rs2_en, in_rs2_addr);
      for (int p = 0; p < 2; p++) if (wbv[p]) m_pend[wa[p]] = 1'b0;
      if (flush && m_ov && m_rde && m_rd != 0) m_pend[m_rd] = 1'b0;
      if (acc && in_rd_en && in_rd_addr != 0) m_pend[in_rd_addr] = 1'b1;
      for (int p = 0; p < 2; p++) if (wbv[p] && wa[p] != 0) m_rf[wa[p]] = wd[p];
      if (acc) begin
        m_rs1 = n_rs1; m_rs2 = n_rs2; m_rde = in_rd_en; m_rd = in_rd_addr; m_ctrl = in_ctrl;
      end
      if (flush)          m_ov = 1'b0;
      else if (acc)       m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/idu1_sb.md
IDU1_SB -- requirements
Module: idu1_sb

Interface
REQ-001 Parameter XLEN, default 32, operand data width.
REQ-002 Parameter NUM_WB, default 2, number of writeback ports (range 1..4).
REQ-003 Parameter CTRL_W, default 64, width of the opaque decode payload passed through unchanged.
REQ-004 Parameter STACK_POINTER_INIT_VALUE, default 32'h80000000, reset value of x2.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid / in_ready  input / output  1 / 1  decode-to-issue handshake.
REQ-008 in_rs1_en, in_rs1_addr, in_rs2_en, in_rs2_addr  input  1,5,1,5  source register use and index.
REQ-009 in_rd_en, in_rd_addr, in_ctrl  input  1,5,CTRL_W  destination use, index, payload.
REQ-010 out_valid / out_ready  output / input  1 / 1  issue-to-EXU handshake.
REQ-011 out_rs1_data, out_rs2_data  output  XLEN each  operands.
REQ-012 out_rd_en, out_rd_addr, out_ctrl  output  1,5,CTRL_W  registered copies of the inputs.
REQ-013 wb_valid, wb_addr, wb_data  input  NUM_WB, NUM_WB*5, NUM_WB*XLEN  writeback ports, port i in slice i.
REQ-014 flush  input  1  kills the instruction held in the output register.
REQ-015 sb_pending  output  32  scoreboard state, bit 0 constantly 0.

Function
REQ-016 Register file: 31 XLEN-bit entries x1..x31; x0 reads 0 and ignores writes.
REQ-017 Writes on every wb_valid[i]; same address on several ports in one cycle: highest index i wins.
REQ-018 Scoreboard pending[31:1]: set on accept when in_rd_en and in_rd_addr!=0; cleared when any wb_valid[i] targets the register; set and clear in the same cycle for the same register: set wins.
REQ-019 clr[r] = any wb_valid[i] with wb_addr[i]==r (with IDU1_SB_FWD_EN), else 0.
REQ-020 hazard = in_valid & ((in_rs1_en & pending[rs1] & ~clr[rs1]) | (in_rs2_en & pending[rs2] & ~clr[rs2]) | (in_rd_en & pending[rd] & ~clr[rd])); pending on x0 never occurs.
REQ-021 in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-022 Accept (in_valid & in_ready) loads output register; out_valid rises next cycle; latency exactly 1 cycle.
REQ-023 Operand captured at accept: register file value, overridden by wb_data of highest-index matching port when IDU1_SB_FWD_EN; rsN_en=0 or address 0 yields 0.
REQ-024 Output register holds all outputs stable while out_valid & ~out_ready.
REQ-025 out_valid & out_ready without accept: out_valid falls next cycle; with accept: back-to-back, out_valid stays 1.
REQ-026 flush: out_valid is 0 the next cycle; if out_valid & out_rd_en & out_rd_addr!=0 at flush, pending[out_rd_addr] cleared; flush has priority over a same-cycle output handshake, which downstream ignores.
REQ-027 Pending bits of instructions already issued survive flush; their writebacks still clear them.
REQ-028 Writeback to a non-pending register is a protocol error; simulation assertion fires.

Reset
REQ-029 rst_n low: out_valid=0, pending all 0, x2=STACK_POINTER_INIT_VALUE, other registers 0, out data/ctrl 0.
REQ-030 Reset mid-operation discards the output instruction and all pending state immediately; in_ready=1 on the first cycle after release with no hazard.

Configuration
REQ-031 Macro IDU1_SB_FWD_EN defined: same-cycle writeback bypass into operand capture and scoreboard clear (REQ-019, REQ-023).
REQ-032 Macro undefined: no bypass; a dependent instruction accepts one cycle after the writeback cycle and reads the register file.

Verification
REQ-033 Reset release -> sb_pending=0, out_valid=0; accept rs1=x2 -> out_rs1_data=32'h80000000 one cycle later.
REQ-034 Issue rd=x5, then rs1=x5 dependent; wb x5=32'hDEADBEEF at cycle t -> FWD_EN: accept at t, out_rs1_data=DEADBEEF; no FWD_EN: accept at t+1.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs unchanged, then drained on out_ready=1.
REQ-036 Out holds rd=x7 pending, flush -> out_valid=0 next cycle, sb_pending[7]=0.
REQ-037 NUM_WB=2, both ports write x3 (1, 2) same cycle -> x3=2, pending[3]=0.
REQ-038 Accept rd=x9 same cycle wb clears x9 (FWD_EN) -> pending[9]=1 afterward.
